mult_div_seq: RTL

- Iterative signed multiply/divide unit plus its own sequencer.
- Driven by the multicycle control unit: MultOp/DivOp pulses launch an operation.
- Holds the HI/LO result registers that mfhi/mflo read.
- The control unit stalls on busy and resumes on done; div_zero is raised to the exception path (EPC write, trap).

---
 rtl/mdu_pkg.sv | 25 ++
 rtl/mult_div_seq_div_step.sv | 27 ++
 rtl/mult_div_seq.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: sequencer state
// encoding, default operand width and the Booth bit-pair decode.
package mdu_pkg;

  localparam int MDU_WIDTH = 32;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_MULT_RUN = 3'd1;
  localparam logic [2:0] ST_DIV_RUN  = 3'd2;
  localparam logic [2:0] ST_DIV_FIX  = 3'd3;
  localparam logic [2:0] ST_FINISH   = 3'd4;

  typedef enum logic [2:0] {
    IDLE     = ST_IDLE,
    MULT_RUN = ST_MULT_RUN,
    DIV_RUN  = ST_DIV_RUN,
    DIV_FIX  = ST_DIV_FIX,
    FINISH   = ST_FINISH
  } mdu_state_t;

  // Booth pair {Q[0], q-1}: 00/11 hold, 01 add multiplicand, 10 subtract it.
  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

// File: rtl/mult_div_seq_div_step.sv
// One restoring-division step on unsigned magnitudes: shift the next dividend
// bit into the partial remainder and subtract the divisor if it fits.
module div_step
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] trial;
  logic [WIDTH:0] diff;

  // The remainder is always below the divisor, so the shifted trial value
  // fits in WIDTH+1 bits and a clear diff MSB means the subtraction fits.
  always_comb begin
    trial   = {rem_in, dvd_bit};
    diff    = trial - {1'b0, divisor};
    q_bit   = ~diff[WIDTH];
    rem_out = q_bit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
  end

endmodule

// File: rtl/mult_div_seq.sv
// Iterative signed multiply (radix-2 Booth) and divide (restoring) unit with
// its own sequencer and the HI/LO result registers read by mfhi/mflo.
module mult_div_seq
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH,
  parameter int CNT_W = 5
) (
  input  logic             clock,
  input  logic             RESET_in,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] mag,
                                                  input logic             neg);
    return neg ? -mag : mag;
  endfunction

  mdu_state_t state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             last_step;

  logic launch_mult;
  logic launch_div;
  logic div_by_zero;

  // Booth datapath: A is one bit wider than the operand so that subtracting
  // the most negative multiplicand cannot overflow.
  logic signed [WIDTH:0]   acc_a;
  logic signed [WIDTH:0]   mcand;
  logic [WIDTH-1:0]        acc_q;
  logic                    acc_qm1;
  logic signed [WIDTH:0]   booth_sum;
  logic signed [WIDTH:0]   booth_a_nxt;
  logic [WIDTH-1:0]        booth_q_nxt;
  logic [2*WIDTH-1:0]      product;

  // Divide datapath: dvd shifts the dividend out at the top and collects the
  // quotient bits at the bottom, so it holds the quotient once the run ends.
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] rem;
  logic             sign_a;
  logic             sign_b;
  logic [WIDTH-1:0] div_rem_nxt;
  logic             div_q_bit;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  assign last_step   = (cnt == CNT_W'(WIDTH - 1));
  assign div_by_zero = (op_b == '0);
  assign launch_mult = (state == IDLE) && start_mult;
  assign launch_div  = (state == IDLE) && start_div && !start_mult && !div_by_zero;

  // Booth step: add/subtract per bit pair, then arithmetic right shift of {A,Q,q-1}.
  always_comb begin
    unique case ({acc_q[0], acc_qm1})
      BOOTH_ADD: booth_sum = acc_a + mcand;
      BOOTH_SUB: booth_sum = acc_a - mcand;
      default:   booth_sum = acc_a;
    endcase
    booth_a_nxt = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
    booth_q_nxt = {booth_sum[0], acc_q[WIDTH-1:1]};
    product     = {booth_a_nxt[WIDTH-1:0], booth_q_nxt};
  end

  div_step #(
    .WIDTH (WIDTH)
  ) u_div_step (
    .rem_in  (rem),
    .dvd_bit (dvd[WIDTH-1]),
    .divisor (dvs),
    .rem_out (div_rem_nxt),
    .q_bit   (div_q_bit)
  );

  // Sign fix-up: quotient negative when signs differ, remainder follows the dividend.
  always_comb begin
    quo_fix = apply_sign(dvd, sign_a ^ sign_b);
    rem_fix = apply_sign(rem, sign_a);
  end

  // Next-state and status outputs of the sequencer.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (launch_mult)     state_nxt = MULT_RUN;
        else if (launch_div) state_nxt = DIV_RUN;
      end
      MULT_RUN: begin
        busy = 1'b1;
        if (last_step) state_nxt = FINISH;
      end
      DIV_RUN: begin
        busy = 1'b1;
        if (last_step) state_nxt = DIV_FIX;
      end
      DIV_FIX: begin
        busy      = 1'b1;
        state_nxt = FINISH;
      end
      FINISH: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control state, iteration counter, divide-by-zero flag and HI/LO results.
  always_ff @(posedge clock or posedge RESET_in) begin
    if (RESET_in) begin
      state    <= IDLE;
      cnt      <= '0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      state    <= state_nxt;
      div_zero <= (state == IDLE) && start_div && !start_mult && div_by_zero;
      if (launch_mult || launch_div)
        cnt <= '0;
      else if (state == MULT_RUN || state == DIV_RUN)
        cnt <= cnt + CNT_W'(1);
      if (state == MULT_RUN && last_step) begin
        hi <= product[2*WIDTH-1:WIDTH];
        lo <= product[WIDTH-1:0];
      end else if (state == DIV_FIX) begin
        hi <= rem_fix;
        lo <= quo_fix;
      end
    end
  end

  // Operand capture and per-cycle iteration of the arithmetic datapath.
  always_ff @(posedge clock) begin
    unique case (state)
      IDLE: begin
        if (launch_mult) begin
          acc_a   <= '0;
          acc_q   <= op_b;
          acc_qm1 <= 1'b0;
          mcand   <= {op_a[WIDTH-1], op_a};
        end else if (launch_div) begin
          dvd    <= magnitude(op_a);
          dvs    <= magnitude(op_b);
          rem    <= '0;
          sign_a <= op_a[WIDTH-1];
          sign_b <= op_b[WIDTH-1];
        end
      end
      MULT_RUN: begin
        acc_a   <= booth_a_nxt;
        acc_q   <= booth_q_nxt;
        acc_qm1 <= acc_q[0];
      end
      DIV_RUN: begin
        rem <= div_rem_nxt;
        dvd <= {dvd[WIDTH-2:0], div_q_bit};
      end
      default: ;
    endcase
  end

endmodule
